// File: rtl/nubus_master_seq_if.sv
// Local request and NuBus master-strobe bundle shared by the sequencer and its user.
// The master modport is the sequencer's view; slave is the requester/bus-driver side.
interface nubus_master_seq_if;
  logic       req_valid;
  logic       req_lock;
  logic [1:0] req_tm;
  logic       arb_win;
  logic       nub_startn;
  logic       nub_ackn;
  logic       nub_tm1n;
  logic       nub_tm0n;
  logic       mst_arbcyn;
  logic       mst_adrcyn;
  logic       mst_dtacyn;
  logic       mst_ownern;
  logic       mst_lockedn;
  logic       mst_tm1n;
  logic       mst_tm0n;
  logic       mst_timeout;
  logic       req_done;
  logic [1:0] req_status;

  modport master (
    input  req_valid, req_lock, req_tm, arb_win, nub_startn, nub_ackn, nub_tm1n, nub_tm0n,
    output mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n, mst_tm0n,
    output mst_timeout, req_done, req_status
  );

  modport slave (
    output req_valid, req_lock, req_tm, arb_win, nub_startn, nub_ackn, nub_tm1n, nub_tm0n,
    input  mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n, mst_tm0n,
    input  mst_timeout, req_done, req_status
  );
endinterface

// File: rtl/nubus_master_seq.sv
// NuBus master transaction sequencer: arbitration, address, data/ACK-wait with timeout,
// optional NULL-ATTN for locked transfers, and completion status back to the requester.
module nubus_master_seq #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ARB_SETTLE  = 2
) (
  input logic              nub_clkn,
  input logic              nub_reset,
  nubus_master_seq_if.master bus
);

  typedef enum logic [2:0] {StIdle, StArb, StAdr, StData, StAttn, StDone} state_e;

  localparam logic [1:0] SettleMax   = 2'(ARB_SETTLE);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] settle_q, settle_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       busy_q, busy_d;
  logic       lock_q, lock_d;
  logic [1:0] tm_q, tm_d;
  logic [1:0] status_q, status_d;

  logic qualify, ack, timeout_hit;

  // Strobes are decoded from state, so an async reset releases the bus at once.
  assign qualify     = ~busy_q & bus.arb_win & bus.nub_startn;
  assign ack         = ~bus.nub_ackn;
  assign timeout_hit = (tcnt_q == TimeoutLast);

  assign bus.mst_tm1n   = ~tm_q[1];
  assign bus.mst_tm0n   = ~tm_q[0];
  assign bus.req_status = status_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tcnt_d   = tcnt_q;
    lock_d   = lock_q;
    tm_d     = tm_q;
    status_d = status_q;
    busy_d   = busy_q;

    bus.mst_arbcyn  = 1'b1;
    bus.mst_adrcyn  = 1'b1;
    bus.mst_dtacyn  = 1'b1;
    bus.mst_ownern  = 1'b1;
    bus.mst_lockedn = 1'b1;
    bus.mst_timeout = 1'b0;
    bus.req_done    = 1'b0;

    if (ack) begin
      busy_d = 1'b0;
    end else if (!bus.nub_startn) begin
      busy_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          lock_d   = bus.req_lock;
          tm_d     = bus.req_tm;
          settle_d = 2'd0;
          state_d  = StArb;
        end
      end
      StArb: begin
        bus.mst_arbcyn = 1'b0;
        if (!bus.req_valid) begin
          state_d = StIdle;
        end else if (qualify) begin
          if (settle_q == SettleMax - 2'd1) begin
            state_d = StAdr;
          end else if (settle_q != SettleMax) begin
            settle_d = settle_q + 2'd1;
          end
        end else begin
          settle_d = 2'd0;
        end
      end
      StAdr: begin
        bus.mst_arbcyn  = 1'b0;
        bus.mst_adrcyn  = 1'b0;
        bus.mst_ownern  = 1'b0;
        bus.mst_lockedn = ~lock_q;
        tcnt_d          = 8'd0;
        state_d         = StData;
      end
      StData: begin
        // A locked transfer keeps RQST* asserted through the data phase.
        bus.mst_arbcyn  = ~lock_q;
        bus.mst_dtacyn  = 1'b0;
        bus.mst_ownern  = 1'b0;
        bus.mst_lockedn = ~lock_q;
        if (ack) begin
          status_d = {~bus.nub_tm1n, ~bus.nub_tm0n};
          state_d  = lock_q ? StAttn : StDone;
        end else if (timeout_hit) begin
          bus.mst_timeout = 1'b1;
          status_d        = 2'b11;
          state_d         = lock_q ? StAttn : StDone;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StAttn: begin
        bus.mst_arbcyn = 1'b0;
        bus.mst_dtacyn = 1'b0;
        bus.mst_ownern = 1'b0;
        state_d        = StDone;
      end
      StDone: begin
        bus.req_done = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q  <= StIdle;
      settle_q <= 2'd0;
      tcnt_q   <= 8'd0;
      busy_q   <= 1'b0;
      lock_q   <= 1'b0;
      tm_q     <= 2'b00;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tcnt_q   <= tcnt_d;
      busy_q   <= busy_d;
      lock_q   <= lock_d;
      tm_q     <= tm_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_nubus_master_seq.sv
// Directed bench for nubus_master_seq: a timestamp-based transaction model checked every
// cycle, plus hand-computed latency/status expectations per scenario.
module tb_nubus_master_seq;

  localparam int TO  = 8;
  localparam int SET = 2;

  localparam int PIdle = 0, PArb = 1, PAdr = 2, PData = 3, PAttn = 4, PDone = 5;

  logic nub_clkn = 1'b0;
  logic nub_reset = 1'b0;

  nubus_master_seq_if bus();

  nubus_master_seq #(
    .TIMEOUT_CYC (TO),
    .ARB_SETTLE  (SET)
  ) dut (
    .nub_clkn  (nub_clkn),
    .nub_reset (nub_reset),
    .bus       (bus)
  );

  always #5 nub_clkn = ~nub_clkn;

  int total = 0;
  int bad = 0;
  int adr_clks = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: phase plus timestamps of the last non-qualifying ARB clock and DATA entry.
  int         m_ph, cyc, m_last_bad, m_data_start;
  logic       m_busy, m_lock;
  logic [1:0] m_tm, m_status;

  always @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      m_ph <= PIdle; cyc <= 0; m_last_bad <= 0; m_data_start <= 0;
      m_busy <= 1'b0; m_lock <= 1'b0; m_tm <= 2'b00; m_status <= 2'b00;
    end else begin
      cyc <= cyc + 1;
      if (!bus.nub_ackn) m_busy <= 1'b0;
      else if (!bus.nub_startn) m_busy <= 1'b1;
      case (m_ph)
        PIdle: if (bus.req_valid) begin
          m_ph <= PArb; m_lock <= bus.req_lock; m_tm <= bus.req_tm; m_last_bad <= cyc;
        end
        PArb: begin
          if (!bus.req_valid) m_ph <= PIdle;
          else if (m_busy || !bus.arb_win || !bus.nub_startn) m_last_bad <= cyc;
          else if (cyc - m_last_bad >= SET) m_ph <= PAdr;
        end
        PAdr: begin m_ph <= PData; m_data_start <= cyc + 1; end
        PData: begin
          if (!bus.nub_ackn) begin
            m_status <= {~bus.nub_tm1n, ~bus.nub_tm0n};
            m_ph <= m_lock ? PAttn : PDone;
          end else if (cyc - m_data_start == TO - 1) begin
            m_status <= 2'b11;
            m_ph <= m_lock ? PAttn : PDone;
          end
        end
        PAttn: m_ph <= PDone;
        default: m_ph <= PIdle;
      endcase
    end
  end

  always @(negedge nub_clkn) begin
    logic [8:0] exp_v, got_v;
    exp_v[8] = !(m_ph == PArb || m_ph == PAdr || m_ph == PAttn || (m_ph == PData && m_lock));
    exp_v[7] = !(m_ph == PAdr);
    exp_v[6] = !(m_ph == PData || m_ph == PAttn);
    exp_v[5] = !(m_ph == PAdr || m_ph == PData || m_ph == PAttn);
    exp_v[4] = !(m_lock && (m_ph == PAdr || m_ph == PData));
    exp_v[3] = ~m_tm[1];
    exp_v[2] = ~m_tm[0];
    exp_v[1] = (m_ph == PData) && bus.nub_ackn && (cyc - m_data_start == TO - 1);
    exp_v[0] = (m_ph == PDone);
    got_v = {bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn, bus.mst_ownern, bus.mst_lockedn,
             bus.mst_tm1n, bus.mst_tm0n, bus.mst_timeout, bus.req_done};
    chk("cycle_outputs", 32'(got_v), 32'(exp_v));
    chk("adr_dta_exclusive", 32'(bus.mst_adrcyn | bus.mst_dtacyn), 32'd1);
    if (exp_v[0]) chk("status_at_done", 32'(bus.req_status), 32'(m_status));
    if (!bus.mst_adrcyn) adr_clks++;
    if (bus.req_done) done_cnt++;
  end

  task automatic step;
    @(posedge nub_clkn);
    #1;
  endtask

  task automatic wait_adr(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (bus.mst_adrcyn !== 1'b0 && k < 40);
  endtask

  task automatic ack_and_finish(input string name, input logic [1:0] exp_status);
    step();
    bus.nub_ackn = 1'b0;
    step();
    bus.nub_ackn = 1'b1;
    chk({name, "_done"}, 32'(bus.req_done), 32'd1);
    chk({name, "_status"}, 32'(bus.req_status), 32'(exp_status));
    bus.req_valid = 1'b0;
    bus.req_lock  = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic arb_seq [4];
    arb_seq = '{1'b1, 1'b0, 1'b1, 1'b1};

    bus.req_valid = 1'b0; bus.req_lock = 1'b0; bus.req_tm = 2'b00; bus.arb_win = 1'b1;
    bus.nub_startn = 1'b1; bus.nub_ackn = 1'b1; bus.nub_tm1n = 1'b1; bus.nub_tm0n = 1'b1;
    #1 nub_reset = 1'b1;
    #1;
    chk("reset_strobes", 32'({bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn, bus.mst_ownern,
                              bus.mst_lockedn, bus.mst_tm1n, bus.mst_tm0n}), 32'h7f);
    chk("reset_done", 32'(bus.req_done | bus.mst_timeout), 32'd0);
    chk("reset_status", 32'(bus.req_status), 32'd0);
    step(); step();
    nub_reset = 1'b0;
    step();

    // Uncontended transfer, ACK on first DATA clock with TM=00.
    adr_clks = 0;
    bus.req_tm = 2'b01; bus.req_valid = 1'b1;
    wait_adr(k);
    chk("t1_start_latency", 32'(k), 32'd3);
    chk("t1_tm0n", 32'(bus.mst_tm0n), 32'd0);
    ack_and_finish("t1", 2'b00);
    chk("t1_adr_clks", 32'(adr_clks), 32'd1);

    // No ACK: timeout on the eighth DATA clock.
    bus.req_tm = 2'b10; bus.req_valid = 1'b1;
    wait_adr(k);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.mst_timeout !== 1'b1 && n < 20);
    chk("t2_timeout_clk", 32'(n), 32'd8);
    step();
    chk("t2_done", 32'(bus.req_done), 32'd1);
    chk("t2_status", 32'(bus.req_status), 32'd3);
    bus.req_valid = 1'b0;
    step();

    // Locked transfer: RQST* held through DATA, then one NULL-ATTN clock.
    bus.req_lock = 1'b1; bus.req_tm = 2'b00; bus.req_valid = 1'b1;
    wait_adr(k);
    chk("t3_adr_locked", 32'({bus.mst_lockedn, bus.mst_arbcyn}), 32'd0);
    step();
    chk("t3_data_rqst", 32'({bus.mst_arbcyn, bus.mst_dtacyn, bus.mst_lockedn}), 32'd0);
    bus.nub_ackn = 1'b0; bus.nub_tm1n = 1'b0; bus.nub_tm0n = 1'b1;
    step();
    bus.nub_ackn = 1'b1; bus.nub_tm1n = 1'b1;
    chk("t3_attn", 32'({bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn, bus.mst_ownern,
                        bus.mst_lockedn}), 32'b01001);
    step();
    chk("t3_done", 32'(bus.req_done), 32'd1);
    chk("t3_status", 32'(bus.req_status), 32'd2);
    bus.req_valid = 1'b0; bus.req_lock = 1'b0;
    step();

    // arb_win 1,0,1,1 restarts the settle count.
    bus.req_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.arb_win = arb_seq[i];
      step();
      chk("t4_arb_toggle_adrcyn", 32'(bus.mst_adrcyn), (i == 3) ? 32'd0 : 32'd1);
    end
    bus.arb_win = 1'b1;
    ack_and_finish("t4", 2'b00);

    // Another master's START* on first ARB clock, its ACK five clocks later.
    bus.req_valid = 1'b1;
    step();
    for (int kk = 2; kk <= 9; kk++) begin
      bus.nub_startn = (kk == 2) ? 1'b0 : 1'b1;
      bus.nub_ackn   = (kk == 7) ? 1'b0 : 1'b1;
      step();
      chk("t5_busy_adrcyn", 32'(bus.mst_adrcyn), (kk == 9) ? 32'd0 : 32'd1);
    end
    bus.nub_tm1n = 1'b0; bus.nub_tm0n = 1'b0;
    ack_and_finish("t5", 2'b11);
    bus.nub_tm1n = 1'b1; bus.nub_tm0n = 1'b1;

    // Request withdrawn during ARB: back to IDLE, no completion.
    done_cnt = 0;
    bus.arb_win = 1'b0; bus.req_valid = 1'b1;
    step();
    chk("t6_arb", 32'(bus.mst_arbcyn), 32'd0);
    bus.req_valid = 1'b0;
    step();
    chk("t6_idle", 32'(bus.mst_arbcyn), 32'd1);
    bus.arb_win = 1'b1;
    step(); step();
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    // Reset in DATA releases the bus without a clock edge.
    bus.req_valid = 1'b1;
    wait_adr(k);
    step();
    done_cnt = 0;
    chk("t7_in_data", 32'(bus.mst_dtacyn), 32'd0);
    #2 nub_reset = 1'b1;
    #1;
    chk("t7_async_release", 32'({bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn,
                                 bus.mst_ownern, bus.mst_lockedn}), 32'h1f);
    bus.req_valid = 1'b0;
    step(); step();
    nub_reset = 1'b0;
    step(); step();
    chk("t7_no_done", 32'(done_cnt), 32'd0);
    chk("t7_idle", 32'(bus.mst_arbcyn), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
